// File: rtl/pkt_pkg.sv
// Shared definitions for the packet buffer: ctrl byte encodings, egress
// FSM states and the end-of-packet test used on both ingress and egress.
package pkt_pkg;

    localparam int unsigned CTRL_W = 8;

    localparam logic [CTRL_W-1:0] CTRL_HDR  = 8'hFF;
    localparam logic [CTRL_W-1:0] CTRL_DATA = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } egress_state_e;

    // A word closes a packet when its ctrl is nonzero and the word before it was payload.
    function automatic logic is_eop(input logic [CTRL_W-1:0] cur, input logic [CTRL_W-1:0] prev);
        return (cur != CTRL_DATA) && (prev == CTRL_DATA);
    endfunction

endpackage

// File: rtl/pkt_buffer_if.sv
// Ingress/egress stream bundle of the packet buffer.
//   in_data/in_wr/in_rdy    : ingress word, valid, ready
//   out_data/out_wr/out_rdy : egress word, valid, downstream ready
// master = traffic source/sink side, slave = the buffer.
interface pkt_buffer_if #(
    parameter int unsigned DWIDTH = 72
);
    logic [DWIDTH-1:0] in_data;
    logic              in_wr;
    logic              in_rdy;
    logic [DWIDTH-1:0] out_data;
    logic              out_wr;
    logic              out_rdy;

    modport master (
        output in_data, in_wr, out_rdy,
        input  in_rdy, out_data, out_wr
    );

    modport slave (
        input  in_data, in_wr, out_rdy,
        output in_rdy, out_data, out_wr
    );
endinterface

// File: rtl/pkt_buffer_ram.sv
// True dual-port, single-clock, read-first block RAM with registered outputs.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset (output registers only)
//   en_a_i/we_a_i/addr_a_i/din_a_i/dout_a_o : port A enable, write, address, data in/out
//   en_b_i/we_b_i/addr_b_i/din_b_i/dout_b_o : port B enable, write, address, data in/out
// A port's output register only updates when its enable is high, so it holds otherwise.
module pkt_buffer_ram #(
    parameter int unsigned DWIDTH = 72,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_a_i,
    input  logic              we_a_i,
    input  logic [AW-1:0]     addr_a_i,
    input  logic [DWIDTH-1:0] din_a_i,
    output logic [DWIDTH-1:0] dout_a_o,
    input  logic              en_b_i,
    input  logic              we_b_i,
    input  logic [AW-1:0]     addr_b_i,
    input  logic [DWIDTH-1:0] din_b_i,
    output logic [DWIDTH-1:0] dout_b_o
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Storage array, no reset.
    always_ff @(posedge clk) begin
        if (we_a_i) mem[addr_a_i] <= din_a_i;
        if (we_b_i) mem[addr_b_i] <= din_b_i;
    end

    // Read-first output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_a_o <= '0;
            dout_b_o <= '0;
        end else begin
            if (en_a_i) dout_a_o <= mem[addr_a_i];
            if (en_b_i) dout_b_o <= mem[addr_b_i];
        end
    end

endmodule

// File: rtl/pkt_buffer.sv
// Circular packet buffer between network ingress and egress, with a
// processor back door into the same memory while fifo_sel=0.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : ingress in_data/in_wr/in_rdy, egress out_data/out_wr/out_rdy
//   fifo_sel          : 1 = network owns memory, 0 = processor owns it
//   stop_tx           : freeze egress reads
//   drop_packet       : rising edge marks the next egressed packet for discard
//   o_ctrl            : ctrl byte of the word written this cycle (0 when idle)
//   tail_addr/head_addr : write/read pointers
//   proc_we/proc_addr/proc_din/proc_dout : processor port, 1-cycle read latency
// Optional: PKT_BUFFER_STATS_EN adds rx_pkt_cnt/tx_pkt_cnt/drop_pkt_cnt.
module pkt_buffer
    import pkt_pkg::*;
#(
    parameter int unsigned DWIDTH = 72,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic              reset,
    pkt_buffer_if.slave       bus,
    input  logic              fifo_sel,
    input  logic              stop_tx,
    input  logic              drop_packet,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [AWIDTH-3:0] tail_addr,
    output logic [AWIDTH-3:0] head_addr,
    input  logic              proc_we,
    input  logic [AWIDTH-1:0] proc_addr,
    input  logic [DWIDTH-1:0] proc_din,
    output logic [DWIDTH-1:0] proc_dout
`ifdef PKT_BUFFER_STATS_EN
    ,
    output logic [31:0]       rx_pkt_cnt,
    output logic [31:0]       tx_pkt_cnt,
    output logic [31:0]       drop_pkt_cnt
`endif
);
    localparam int unsigned PW = AWIDTH - 2;

    // Pointers carry one extra wrap bit above the address bits.
    logic [PW:0]       tail_q, tail_d, head_q, head_d;
    logic              empty, full, wr_en, rd_en, proc_sel;
    logic [CTRL_W-1:0] in_ctrl, pres_ctrl;
    logic [DWIDTH-1:0] rd_data_b;

    egress_state_e     state_q, state_d;
    logic              drop_pending_q, drop_pending_d;
    logic [CTRL_W-1:0] prev_ctrl_q, prev_ctrl_d;
    logic              out_wr_q, out_wr_d;
    logic              pres_valid_q;
    logic              drop_prev_q;
    logic              drop_rise, pres_eop;

    logic              unused_addr_bit;
    assign unused_addr_bit = proc_addr[PW];

    assign empty     = (tail_q == head_q);
    assign full      = (tail_q[PW-1:0] == head_q[PW-1:0]) && (tail_q[PW] != head_q[PW]);
    assign in_ctrl   = bus.in_data[DWIDTH-1 -: CTRL_W];
    assign pres_ctrl = rd_data_b[DWIDTH-1 -: CTRL_W];

    assign bus.in_rdy = !full && fifo_sel && !reset;
    assign wr_en      = bus.in_wr && bus.in_rdy;
    assign rd_en      = !empty && fifo_sel && !stop_tx && bus.out_rdy && !reset;
    assign proc_sel   = !fifo_sel && !proc_addr[AWIDTH-1] && !reset;
    assign o_ctrl     = wr_en ? in_ctrl : CTRL_DATA;

    assign tail_d = wr_en ? tail_q + (PW+1)'(1) : tail_q;
    assign head_d = rd_en ? head_q + (PW+1)'(1) : head_q;

    assign tail_addr    = tail_q[PW-1:0];
    assign head_addr    = head_q[PW-1:0];
    assign bus.out_data = rd_data_b;
    assign bus.out_wr   = out_wr_q;

    assign drop_rise = drop_packet && !drop_prev_q;
    // The word read last cycle is on rd_data_b now; it is the one checked for EOP.
    assign pres_eop  = pres_valid_q && is_eop(pres_ctrl, prev_ctrl_q);

    // Port A: network writes or processor access; port B: egress reads.
    pkt_buffer_ram #(
        .DWIDTH (DWIDTH),
        .AW     (PW)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .en_a_i   (proc_sel),
        .we_a_i   (wr_en || (proc_sel && proc_we)),
        .addr_a_i (fifo_sel ? tail_q[PW-1:0] : proc_addr[PW-1:0]),
        .din_a_i  (fifo_sel ? bus.in_data : proc_din),
        .dout_a_o (proc_dout),
        .en_b_i   (rd_en),
        .we_b_i   (1'b0),
        .addr_b_i (head_q[PW-1:0]),
        .din_b_i  ('0),
        .dout_b_o (rd_data_b)
    );

    // State and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            drop_pending_q <= 1'b0;
            prev_ctrl_q    <= CTRL_HDR;
            out_wr_q       <= 1'b0;
            pres_valid_q   <= 1'b0;
            drop_prev_q    <= 1'b0;
            tail_q         <= '0;
            head_q         <= '0;
        end else begin
            state_q        <= state_d;
            drop_pending_q <= drop_pending_d;
            prev_ctrl_q    <= prev_ctrl_d;
            out_wr_q       <= out_wr_d;
            pres_valid_q   <= rd_en;
            drop_prev_q    <= drop_packet;
            tail_q         <= tail_d;
            head_q         <= head_d;
        end
    end

    // Egress next state. The EOP of the presented word is resolved first so a
    // back-to-back read of the next header already sees the packet boundary.
    always_comb begin
        state_d        = state_q;
        drop_pending_d = drop_pending_q;
        prev_ctrl_d    = prev_ctrl_q;
        out_wr_d       = 1'b0;
        if (pres_valid_q) prev_ctrl_d = pres_ctrl;
        case (state_q)
            SEND: if (pres_eop) state_d = IDLE;
            DROP: if (pres_eop) begin
                state_d        = IDLE;
                drop_pending_d = 1'b0;
            end
            default: ;
        endcase
        if (drop_rise) drop_pending_d = 1'b1;
        if (rd_en) begin
            if (state_d == IDLE) state_d = drop_pending_d ? DROP : SEND;
            out_wr_d = (state_d == SEND);
        end
    end

`ifdef PKT_BUFFER_STATS_EN
    logic [CTRL_W-1:0] wr_prev_ctrl_q;
    logic [31:0]       rx_cnt_q, tx_cnt_q, drop_cnt_q;

    // Packet counters; ingress EOP tracked on its own ctrl history.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_prev_ctrl_q <= CTRL_HDR;
            rx_cnt_q       <= '0;
            tx_cnt_q       <= '0;
            drop_cnt_q     <= '0;
        end else begin
            if (wr_en) begin
                wr_prev_ctrl_q <= in_ctrl;
                if (is_eop(in_ctrl, wr_prev_ctrl_q)) rx_cnt_q <= rx_cnt_q + 32'd1;
            end
            if (pres_eop && state_q == SEND) tx_cnt_q   <= tx_cnt_q + 32'd1;
            if (pres_eop && state_q == DROP) drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign rx_pkt_cnt   = rx_cnt_q;
    assign tx_pkt_cnt   = tx_cnt_q;
    assign drop_pkt_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_buffer.sv
// Scoreboard bench for pkt_buffer: accepted words that should leave the
// buffer are queued at drive time and popped on every out_wr.
module tb_pkt_buffer;
    import pkt_pkg::*;

    localparam int unsigned DW = 72;
    localparam int unsigned AW = 10;
    localparam int unsigned PW = AW - 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_sel, stop_tx, drop_packet;
    logic [7:0]    o_ctrl;
    logic [PW-1:0] tail_addr, head_addr;
    logic          proc_we;
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_din, proc_dout;
`ifdef PKT_BUFFER_STATS_EN
    logic [31:0]   rx_pkt_cnt, tx_pkt_cnt, drop_pkt_cnt;
`endif

    pkt_buffer_if #(.DWIDTH(DW)) bus ();

    pkt_buffer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fifo_sel    (fifo_sel),
        .stop_tx     (stop_tx),
        .drop_packet (drop_packet),
        .o_ctrl      (o_ctrl),
        .tail_addr   (tail_addr),
        .head_addr   (head_addr),
        .proc_we     (proc_we),
        .proc_addr   (proc_addr),
        .proc_din    (proc_din),
        .proc_dout   (proc_dout)
`ifdef PKT_BUFFER_STATS_EN
        ,
        .rx_pkt_cnt  (rx_pkt_cnt),
        .tx_pkt_cnt  (tx_pkt_cnt),
        .drop_pkt_cnt(drop_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            out_cnt = 0;
    int            first_out_cyc = -1;
    int            exp_ptr = 0;
    int            seq     = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_word;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Egress monitor: every out_wr must match the oldest expected word.
    always @(negedge clk) begin
        if (bus.out_wr === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_out_wr", DW'(bus.out_wr), '0);
            end else begin
                exp_word = sb.pop_front();
                check("out_data", bus.out_data, exp_word);
            end
            if (out_cnt == 0) first_out_cyc = cyc;
            out_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one word expected to be accepted; call at posedge+1.
    task automatic send_word(input logic [7:0] ctrl, input bit expect_out);
        logic [31:0]   r;
        logic [DW-1:0] w;
        r = $urandom();
        w = {ctrl, 32'(seq), r};
        seq++;
        bus.in_data = w;
        bus.in_wr   = 1'b1;
        if (expect_out) sb.push_back(w);
        @(negedge clk);
        check("in_rdy_accept", DW'(bus.in_rdy), DW'(1'b1));
        check("o_ctrl", DW'(o_ctrl), DW'(ctrl));
        @(posedge clk);
        #1;
        bus.in_wr = 1'b0;
        exp_ptr++;
    endtask

    task automatic send_pkt(input int n, input logic [7:0] eop, input bit expect_out);
        send_word(CTRL_HDR, expect_out);
        for (int i = 0; i < n - 2; i++) send_word(CTRL_DATA, expect_out);
        send_word(eop, expect_out);
    endtask

    task automatic wait_drain(input int max_cyc);
        int k;
        k = 0;
        while (sb.size() != 0 && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) check("drain_timeout", DW'(sb.size()), '0);
        step(3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base, snap, k;
        reset = 1'b1; fifo_sel = 1'b1; stop_tx = 1'b0; drop_packet = 1'b0;
        proc_we = 1'b0; proc_addr = '0; proc_din = '0;
        bus.in_data = '0; bus.in_wr = 1'b0; bus.out_rdy = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy",    DW'(bus.in_rdy), '0);
        check("rst_out_wr",    DW'(bus.out_wr), '0);
        check("rst_out_data",  bus.out_data,    '0);
        check("rst_o_ctrl",    DW'(o_ctrl),     '0);
        check("rst_proc_dout", proc_dout,       '0);
        check("rst_tail",      DW'(tail_addr),  '0);
        check("rst_head",      DW'(head_addr),  '0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_rdy", DW'(bus.in_rdy), DW'(1'b1));

        // Single 4-word packet, latency and order
        step(1);
        bus.out_rdy = 1'b1;
        t0 = cyc;
        send_pkt(4, 8'h01, 1'b1);
        check("t1_tail", DW'(tail_addr), DW'(PW'(exp_ptr)));
        wait_drain(50);
        check("t1_head", DW'(head_addr), DW'(PW'(exp_ptr)));
        check("t1_out_cnt", DW'(out_cnt), DW'(4));
        check("t1_first_lat", DW'(first_out_cyc), DW'(t0 + 2));

        // Fill all 256 words, then overflow attempt
        bus.out_rdy = 1'b0;
        step(1);
        for (int p = 0; p < 64; p++) send_pkt(4, 8'h01, 1'b1);
        check("full_in_rdy", DW'(bus.in_rdy), '0);
        check("full_tail", DW'(tail_addr), DW'(PW'(exp_ptr)));
        bus.in_data = {8'hFF, 64'hDEAD_BEEF_0BAD_F00D};
        bus.in_wr   = 1'b1;
        @(negedge clk);
        check("ovf_o_ctrl", DW'(o_ctrl), '0);
        @(posedge clk); #1;
        bus.in_wr = 1'b0;
        check("ovf_tail", DW'(tail_addr), DW'(PW'(exp_ptr)));
        bus.out_rdy = 1'b1;
        wait_drain(400);
        check("fill_head", DW'(head_addr), DW'(PW'(exp_ptr)));
        check("fill_in_rdy", DW'(bus.in_rdy), DW'(1'b1));

        // stop_tx after 2nd egress word of 6
        bus.out_rdy = 1'b0;
        step(1);
        send_pkt(6, 8'h02, 1'b1);
        base = out_cnt;
        bus.out_rdy = 1'b1;
        k = 0;
        while (out_cnt < base + 2 && k < 30) begin
            @(negedge clk); #1;
            k++;
        end
        stop_tx = 1'b1;
        repeat (8) @(negedge clk);
        check("stop_extra", DW'((out_cnt - base - 2) <= 1), DW'(1'b1));
        snap = out_cnt;
        repeat (8) @(negedge clk);
        check("stop_frozen", DW'(out_cnt), DW'(snap));
        stop_tx = 1'b0;
        wait_drain(50);
        check("stop_total", DW'(out_cnt - base), DW'(6));

        // Drop packet A, keep packet B
        drop_packet = 1'b1;
        step(1);
        drop_packet = 1'b0;
        base = out_cnt;
        send_pkt(5, 8'h03, 1'b0);
        send_pkt(3, 8'h04, 1'b1);
        wait_drain(60);
        step(5);
        check("drop_pending", DW'(dut.drop_pending_q), '0);
        check("drop_out_cnt", DW'(out_cnt - base), DW'(3));
        check("drop_head", DW'(head_addr), DW'(PW'(exp_ptr)));

        // Processor access while fifo_sel=0
        fifo_sel = 1'b0;
        step(1);
        proc_addr = 10'd3; proc_din = 72'hAB; proc_we = 1'b1;
        bus.in_data = {8'hFF, 64'h1}; bus.in_wr = 1'b1;
        @(negedge clk);
        check("proc_in_rdy", DW'(bus.in_rdy), '0);
        step(1);
        proc_we = 1'b0; bus.in_wr = 1'b0;
        step(1);
        check("proc_dout", proc_dout, 72'hAB);
        proc_addr = 10'h205;
        step(2);
        check("proc_hold", proc_dout, 72'hAB);
        check("proc_tail", DW'(tail_addr), DW'(PW'(exp_ptr)));
        check("proc_head", DW'(head_addr), DW'(PW'(exp_ptr)));
        fifo_sel = 1'b1; proc_addr = '0;
        step(1);

        // Wrap-around: 300 words streamed
        for (int p = 0; p < 75; p++) send_pkt(4, 8'h01, 1'b1);
        wait_drain(100);
        check("wrap_tail", DW'(tail_addr), DW'(PW'(exp_ptr)));
        check("wrap_head", DW'(head_addr), DW'(PW'(exp_ptr)));

        // Reset in the middle of a packet
        bus.out_rdy = 1'b0;
        send_word(CTRL_HDR, 1'b0);
        send_word(CTRL_DATA, 1'b0);
        reset = 1'b1;
        step(2);
        check("mid_rst_tail",   DW'(tail_addr),  '0);
        check("mid_rst_head",   DW'(head_addr),  '0);
        check("mid_rst_out_wr", DW'(bus.out_wr), '0);
        reset = 1'b0;
        exp_ptr = 0;
        bus.out_rdy = 1'b1;
        step(1);
        send_pkt(3, 8'h05, 1'b1);
        wait_drain(50);
        check("after_rst_head", DW'(head_addr), DW'(PW'(exp_ptr)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_buffer.md
Name: pkt_buffer

Overview:
- Upstream neighbour of the packet-processing controller: circular packet buffer between the network ingress and egress.
- Stores 72-bit words (64 data + 8 ctrl) and exports `tail_addr`, `head_addr` and the ctrl byte being written (`o_ctrl`) for the controller's SOP/EOP tracking.
- Obeys the controller's `fifo_sel`, `stop_tx` and `drop_packet`.
- While `fifo_sel`=0, the processor owns the memory through a secondary port.

Parameters:
- DWIDTH, 72, word width; ctrl is [DWIDTH-1:DWIDTH-8], data is the rest.
- AWIDTH, 10, processor address width; the buffer holds 2**(AWIDTH-2) words.

Ports:
- clk  input  1  single clock
- reset  input  1  synchronous, active-high reset
- in_data  input  DWIDTH  ingress word
- in_wr  input  1  ingress word valid
- in_rdy  output  1  buffer can accept a word
- out_data  output  DWIDTH  egress word
- out_wr  output  1  egress word valid
- out_rdy  input  1  downstream can accept a word
- fifo_sel  input  1  1 = network owns memory, 0 = processor owns it
- stop_tx  input  1  freeze egress
- drop_packet  input  1  discard the next egressed packet
- o_ctrl  output  8  ctrl byte of the word written this cycle (0 when idle)
- tail_addr  output  AWIDTH-2  write pointer
- head_addr  output  AWIDTH-2  read pointer
- proc_we  input  1  processor write enable
- proc_addr  input  AWIDTH  processor word address; bit AWIDTH-1 = 0 selects the buffer
- proc_din  input  DWIDTH  processor write data
- proc_dout  output  DWIDTH  processor read data, 1-cycle latency

Behaviour:
- Reset values: tail, head and wrap bits 0; `out_wr`=0; `out_data`=0; `o_ctrl`=0; `proc_dout`=0; `in_rdy`=0 during reset, then 1; egress FSM in IDLE; `drop_pending`=0.
- Pointer width and wrap:
  - Pointers are AWIDTH-2 bits plus one wrap bit each.
  - Empty = pointers equal and wrap bits equal.
  - Full = pointers equal and wrap bits differ.
  - Each pointer increments modulo 2**(AWIDTH-2); its wrap bit toggles on rollover.
- Ingress:
  - `in_rdy` = `!full && fifo_sel`.
  - Write when `in_wr && in_rdy`: the word goes to mem[tail], tail increments, and `o_ctrl` equals the word's ctrl byte combinationally in that cycle.
  - If `in_wr` is asserted while `in_rdy`=0, the word is dropped silently and no pointer moves.
- Egress FSM has three states.
  - IDLE: read when not empty, `fifo_sel`=1, `stop_tx`=0 and `out_rdy`=1. The read word is presented 1 cycle later. Go to SEND, or to DROP if `drop_pending`=1.
  - SEND: keep reading under the same conditions. `out_wr`=1 for exactly the cycle after each read.
  - DROP: identical reads, but `out_wr` is forced to 0.
  - SEND/DROP exit: when a read word has ctrl≠0 and the previous word had ctrl=0 (EOP), return to IDLE. On leaving DROP, clear `drop_pending`.
- Packet format: the header word has ctrl=0xFF, payload words have ctrl=0x00, and the EOP word has a nonzero ctrl.
- `drop_pending` is set on a rising edge of `drop_packet` and held until the dropped packet's EOP has been consumed.
- `stop_tx`, `fifo_sel`=0 or `out_rdy`=0 mid-packet pauses reads only. The word already read is still presented once, with no duplication.
- Processor port:
  - When `fifo_sel`=0 and proc_addr[AWIDTH-1]=0: write mem[proc_addr[AWIDTH-3:0]] on `proc_we`; `proc_dout` is the read data one cycle later.
  - Otherwise `proc_dout` holds its value.
  - Processor writes never move the pointers.
- Same-cycle ingress write and egress read: both are allowed and the pointers update independently.
- When not full, the full count of 2**(AWIDTH-2) words is usable.
- Reset mid-packet: all state returns to reset values and buffered contents are discarded logically.

Optional Feature:
- Macro: `PKT_BUFFER_STATS_EN`.
- When defined, adds three 32-bit outputs `rx_pkt_cnt`, `tx_pkt_cnt` and `drop_pkt_cnt`:
  - `rx_pkt_cnt` increments on each written EOP.
  - `tx_pkt_cnt` increments on each EOP emitted in SEND.
  - `drop_pkt_cnt` increments on each EOP consumed in DROP.
  - All three reset to 0 and wrap at 2**32.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package `pkt_pkg`:
  - ctrl constants CTRL_HDR=8'hFF and CTRL_DATA=8'h00
  - egress state encodings IDLE/SEND/DROP
  - a function `is_eop(cur,prev)`
- One sub-module: `pkt_buffer_ram`, a true dual-port, single-clock, read-first BRAM with registered outputs, shared by the egress and processor paths.

Test Plan:
- Reset, then write a 4-word packet (FF, 00, 00, 01) with `out_rdy`=1 -> `tail_addr`=4 and `o_ctrl` pulses FF, 00, 00, 01. Four `out_wr` pulses follow in order, the first one cycle after the first read, and `head_addr`=4.
- Fill all 256 words with `out_rdy`=0 -> `in_rdy`=0 after word 256, and a 257th `in_wr` does not change `tail_addr`.
- Assert `stop_tx` after the 2nd egress word of 6 -> at most one more `out_wr`, then none until `stop_tx` falls. The complete 6-word sequence arrives without gaps or duplicates.
- Pulse `drop_packet`, then send packets A (5 words) and B (3 words) -> no `out_wr` for A, B emitted intact, `drop_pending`=0 afterwards.
- With `fifo_sel`=0, the processor writes 0xAB at address 3 and reads it back -> `proc_dout`=0xAB one cycle after the read. `in_rdy`=0, and `head_addr`/`tail_addr` are unchanged.
- Wrap-around: run 300 words through continuously -> pointers roll past 255 to 0 and the data order is preserved.
